// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave front-end that turns 10-bit MOSI frames into RAM command words
// and shifts RAM read data back out on MISO.
module spi_slave_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);
  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W + 2);
  localparam logic [CNT_W-1:0] TXN  = CNT_W'(DATA_W);
  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q, tx_cnt_q;
  logic [DATA_W:0]     rx_sr_q;
  logic [DATA_W-1:0]   tx_sr_q;
  logic [DATA_W+1:0]   rx_data_q;
  logic                rx_valid_q, miso_q, rd_addr_done_q, tx_act_q, tx_done_q;
  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      tx_cnt_q       <= '0;
      rx_sr_q        <= '0;
      tx_sr_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      miso_q         <= 1'b0;
      rd_addr_done_q <= 1'b0;
      tx_act_q       <= 1'b0;
      tx_done_q      <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (SS_n) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        tx_cnt_q  <= '0;
        miso_q    <= 1'b0;
        tx_act_q  <= 1'b0;
        tx_done_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: state_q <= CHK_CMD;
          CHK_CMD: begin
            rx_sr_q <= {rx_sr_q[DATA_W-1:0], MOSI};
            cnt_q   <= CNT_W'(1);
            state_q <= !MOSI ? WRITE : rd_addr_done_q ? READ_DATA : READ_ADD;
          end
          default: begin
            if (cnt_q < FULL) begin
              rx_sr_q <= {rx_sr_q[DATA_W-1:0], MOSI};
              cnt_q   <= cnt_q + CNT_W'(1);
              if (cnt_q == LAST) begin
                rx_data_q  <= {rx_sr_q, MOSI};
                rx_valid_q <= 1'b1;
                if (state_q == READ_ADD) rd_addr_done_q <= 1'b1;
                else if (state_q == READ_DATA) rd_addr_done_q <= 1'b0;
              end
            end else if (state_q == READ_DATA) begin
              // tx_done_q keeps later tx_valid pulses in this frame from restarting the shift-out
              if (tx_act_q) begin
                if (tx_cnt_q == TXN) begin
                  miso_q    <= 1'b0;
                  tx_act_q  <= 1'b0;
                  tx_done_q <= 1'b1;
                end else begin
                  miso_q   <= tx_sr_q[DATA_W-2];
                  tx_sr_q  <= tx_sr_q << 1;
                  tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                end
              end else if (tx_valid && !tx_done_q) begin
                tx_sr_q  <= tx_data;
                miso_q   <= tx_data[DATA_W-1];
                tx_cnt_q <= CNT_W'(1);
                tx_act_q <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: directed checks of spi_slave_if framing, readback, abort and reset.
module tb_spi_slave_if;
  logic       clk = 1'b0, rst_n = 1'b0, SS_n = 1'b1, MOSI = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       MISO, rx_valid;
  logic [9:0] rx_data;
  int         errors = 0, checks = 0;
  always #5 clk = ~clk;
  spi_slave_if #(.DATA_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
  );
  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [9:0] w);
    @(negedge clk) SS_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1("rx_valid_early", rx_valid, 1'b0);
      chk1("miso_during_rx", MISO, 1'b0);
      MOSI = w[9-i];
    end
    @(negedge clk);
    chk1("rx_valid_pulse", rx_valid, 1'b1);
    chk10("rx_data", rx_data, w);
    @(negedge clk);
    chk1("rx_valid_drop", rx_valid, 1'b0);
  endtask
  task automatic tx(input logic [7:0] d, input logic on);
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      tx_valid = 1'b0;
      chk1("miso_bit", MISO, on & d[i]);
    end
    @(negedge clk);
    chk1("miso_tail", MISO, 1'b0);
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk1("miso_retrigger", MISO, 1'b0);
    @(negedge clk);
    chk1("miso_quiet", MISO, 1'b0);
  endtask
  task automatic rel();
    @(negedge clk) SS_n = 1'b1;
  endtask
  task automatic partial(input logic [9:0] w, input int n, input logic same, input logic [9:0] hold);
    @(negedge clk) SS_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk1("rx_valid_partial", rx_valid, 1'b0);
      MOSI = w[9-i];
      if (same && i == n - 1) SS_n = 1'b1;
    end
    if (!same) @(negedge clk) SS_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk1("abort_no_valid", rx_valid, 1'b0);
      chk1("abort_miso", MISO, 1'b0);
    end
    chk10("abort_hold", rx_data, hold);
  endtask
  initial begin
    logic [9:0] w;
    repeat (2) @(negedge clk);
    chk10("reset_rx_data", rx_data, 10'h000);
    chk1("reset_rx_valid", rx_valid, 1'b0);
    chk1("reset_miso", MISO, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    send(10'h006);
    tx(8'hA3, 1'b0);
    rel();
    w = 10'h2AA;
    @(negedge clk) SS_n = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk) MOSI = w[9-i];
    #2 rst_n = 1'b0;
    #1;
    chk10("async_rst_rx_data", rx_data, 10'h000);
    chk1("async_rst_rx_valid", rx_valid, 1'b0);
    chk1("async_rst_miso", MISO, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 4; i < 10; i++) begin
      @(negedge clk);
      chk1("post_rst_no_valid", rx_valid, 1'b0);
      MOSI = w[9-i];
    end
    @(negedge clk);
    chk1("post_rst_no_valid", rx_valid, 1'b0);
    SS_n = 1'b1;
    @(negedge clk);
    chk1("post_rst_idle_valid", rx_valid, 1'b0);
    chk10("post_rst_rx_data", rx_data, 10'h000);
    send(10'h1A3);
    tx(8'hA3, 1'b0);
    rel();
    send(10'h206);
    tx(8'h5C, 1'b0);
    rel();
    send(10'h300);
    tx(8'hA3, 1'b1);
    rel();
    send(10'h3FF);
    tx(8'hA3, 1'b0);
    rel();
    partial(10'h3C0, 6, 1'b0, 10'h3FF);
    partial(10'h0F0, 10, 1'b1, 10'h3FF);
    send(10'h3C5);
    tx(8'h5A, 1'b1);
    rel();
    send(10'h255);
    tx(8'hA3, 1'b0);
    rel();
    @(negedge clk);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk1("idle_tx_valid_miso", MISO, 1'b0);
    @(negedge clk);
    chk1("idle_tx_valid_miso2", MISO, 1'b0);
    chk1("idle_rx_valid", rx_valid, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
